// File: rtl/nim_turn_ctrl_if.sv
// Keypad-to-sequencer key handshake: the keypad (master) holds key_valid/key_code
// until the sequencer (slave) returns a one-cycle key_ack.
interface nim_turn_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ack;

    modport master (output key_valid, output key_code, input key_ack);
    modport slave  (input key_valid, input key_code, output key_ack);
endinterface

// File: rtl/nim_turn_ctrl.sv
// Two-player take-away game sequencer: consumes keypad keys, tracks setup entry,
// remaining count, pending take and turn, and drives the registered display word.
module nim_turn_ctrl #(
    parameter int unsigned MAX_TAKE = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    nim_turn_ctrl_if.slave     kif,
    output logic [15:0]        disp_data,
    output logic               cur_player,
    output logic               game_over,
    output logic               move_err,
    output logic [1:0]         state
);
    // Handshake: a key is taken on a posedge with key_valid=1 and key_ack=0;
    // key_ack is then high for exactly one cycle, during which nothing is taken.
    typedef enum logic [1:0] {
        ST_SETUP = 2'b00,
        ST_TURN  = 2'b01,
        ST_OVER  = 2'b10,
        ST_BAD   = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [15:0] total_q, total_d;
    logic [3:0]  take_q, take_d;
    logic        winner_q, winner_d;
    logic        player_q, player_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        over_q, over_d;
    logic [15:0] disp_q, disp_d;

    logic        consume, key_start, key_confirm, key_digit, key_is_take;
    logic        bad_take, reject;
    logic [15:0] diff;

    assign consume     = kif.key_valid && !ack_q && (state_q != ST_BAD);
    assign key_start   = (kif.key_code == 4'hE);
    assign key_confirm = (kif.key_code == 4'hF);
    assign key_digit   = (kif.key_code <= 4'hD);
    assign key_is_take = key_digit && (kif.key_code != 4'd0) && (32'(kif.key_code) <= MAX_TAKE);
    assign bad_take    = (take_q == 4'd0) || ({12'b0, take_q} > total_q);
    assign reject      = consume && (state_q == ST_TURN) && key_confirm && bad_take;
    assign diff        = total_q - {12'b0, take_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SETUP;
            entry_q  <= '0;
            total_q  <= '0;
            take_q   <= '0;
            winner_q <= 1'b0;
            player_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            over_q   <= 1'b0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            total_q  <= total_d;
            take_q   <= take_d;
            winner_q <= winner_d;
            player_q <= player_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            over_q   <= over_d;
            disp_q   <= disp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        total_d  = total_q;
        take_d   = take_q;
        winner_d = winner_q;
        player_d = player_q;
        case (state_q)
            ST_SETUP: begin
                if (consume) begin
                    if (key_digit) begin
                        entry_d = {entry_q[11:0], kif.key_code};
                    end else if (key_start && (entry_q != 16'd0)) begin
                        total_d  = entry_q;
                        take_d   = 4'd0;
                        player_d = 1'b0;
                        state_d  = ST_TURN;
                    end
                end
            end
            ST_TURN: begin
                if (consume) begin
                    if (key_start) begin
                        entry_d = '0;
                        take_d  = 4'd0;
                        state_d = ST_SETUP;
                    end else if (key_confirm) begin
                        if (!bad_take) begin
                            total_d = diff;
                            take_d  = 4'd0;
                            // Misere: whoever takes the last unit loses.
                            if (diff == 16'd0) begin
                                winner_d = ~player_q;
                                state_d  = ST_OVER;
                            end else begin
                                player_d = ~player_q;
                            end
                        end
                    end else if (key_is_take) begin
                        take_d = kif.key_code;
                    end
                end
            end
            ST_OVER: begin
                if (consume && key_start) begin
                    entry_d = '0;
                    state_d = ST_SETUP;
                end
            end
            default: begin
                entry_d = '0;
                state_d = ST_SETUP;
            end
        endcase
    end

    // Outputs are computed from next-state values so display tracks state latency.
    always_comb begin
        ack_d  = consume;
        err_d  = reject;
        over_d = (state_d == ST_OVER);
        disp_d = '0;
        case (state_d)
            ST_SETUP: disp_d = entry_d;
            ST_TURN:  disp_d = (take_d == 4'd0) ? total_d
                                                : {4'hA + {3'b0, player_d}, 8'h00, take_d};
            ST_OVER:  disp_d = {12'hEEE, 3'b0, winner_d} + 16'd1;
            default:  disp_d = '0;
        endcase
    end

    assign kif.key_ack = ack_q;
    assign disp_data   = disp_q;
    assign cur_player  = player_q;
    assign game_over   = over_q;
    assign move_err    = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_nim_turn_ctrl.sv
// Bench for nim_turn_ctrl: directed game scenarios plus random key streams,
// compared against a rule-level model of the game.
module tb_nim_turn_ctrl;
  localparam int MAX_TAKE = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] disp_data;
  logic        cur_player;
  logic        game_over;
  logic        move_err;
  logic [1:0]  state;

  nim_turn_ctrl_if kif ();

  nim_turn_ctrl #(.MAX_TAKE(MAX_TAKE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kif        (kif),
    .disp_data  (disp_data),
    .cur_player (cur_player),
    .game_over  (game_over),
    .move_err   (move_err),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // game model: 0 setup, 1 turn, 2 over
  int m_state, m_entry, m_total, m_take, m_winner, m_player;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_entry = 0; m_total = 0; m_take = 0;
    m_winner = 0; m_player = 0; m_err = 0;
  endtask

  task automatic m_apply(input int k);
    m_err = 0;
    case (m_state)
      0: begin
        if (k <= 13) m_entry = ((m_entry * 16) + k) % 65536;
        else if (k == 14 && m_entry != 0) begin
          m_total = m_entry; m_take = 0; m_player = 0; m_state = 1;
        end
      end
      1: begin
        if (k == 14) begin
          m_entry = 0; m_take = 0; m_state = 0;
        end else if (k == 15) begin
          if (m_take == 0 || m_take > m_total) m_err = 1;
          else begin
            m_total = m_total - m_take;
            m_take = 0;
            if (m_total == 0) begin
              m_winner = 1 - m_player; m_state = 2;
            end else m_player = 1 - m_player;
          end
        end else if (k >= 1 && k <= MAX_TAKE) m_take = k;
      end
      default: begin
        if (k == 14) begin
          m_entry = 0; m_state = 0;
        end
      end
    endcase
  endtask

  function automatic logic [15:0] exp_disp();
    int v;
    if (m_state == 0) v = m_entry;
    else if (m_state == 1) v = (m_take == 0) ? m_total : ((10 + m_player) * 4096 + m_take);
    else v = 16'hEEE1 + m_winner;
    return v[15:0];
  endfunction

  task automatic check_outputs(input string tag, input logic exp_ack, input logic exp_err);
    check({tag, ".ack"}, 32'(kif.key_ack), 32'(exp_ack));
    check({tag, ".err"}, 32'(move_err), 32'(exp_err));
    check({tag, ".disp"}, 32'(disp_data), 32'(exp_disp()));
    check({tag, ".state"}, 32'(state), m_state);
    check({tag, ".player"}, 32'(cur_player), m_player);
    check({tag, ".over"}, 32'(game_over), 32'(m_state == 2));
  endtask

  // driver: one key, valid dropped one cycle after the consuming edge
  task automatic send_key(input int k, input string tag);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = k[3:0];
    @(posedge clk);
    m_apply(k);
    @(negedge clk);
    check_outputs(tag, 1'b1, m_err);
    kif.key_valid = 1'b0;
    @(negedge clk);
    check_outputs({tag, "+1"}, 1'b0, 1'b0);
  endtask

  initial begin
    int k, r;
    rst_n = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    m_reset();
    #12;
    check_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // setup entry
    send_key(1, "setup1");
    send_key(2, "setup2");
    check("setup_disp", 32'(disp_data), 32'h0012);
    send_key(14, "start");
    check("start_state", 32'(state), 32'h1);
    send_key(14, "abort");

    // normal turn
    send_key(5, "n5");
    send_key(14, "nstart");
    send_key(2, "ntake");
    check("ntake_disp", 32'(disp_data), 32'hA002);
    send_key(15, "nconf");
    check("nconf_disp", 32'(disp_data), 32'h0003);
    check("nconf_player", 32'(cur_player), 32'h1);
    send_key(14, "nabort");

    // rejections
    send_key(2, "r2");
    send_key(14, "rstart");
    send_key(15, "rnotake");
    check("rnotake_err", 32'(move_err), 32'h0);
    send_key(3, "rtake3");
    send_key(15, "rover");

    // game end: p1 takes 1, p2 takes last
    send_key(1, "e1");
    send_key(15, "econf1");
    send_key(1, "e2");
    send_key(15, "econf2");
    check("end_disp", 32'(disp_data), 32'hEEE1);
    check("end_over", 32'(game_over), 32'h1);
    send_key(7, "over_ignore");
    send_key(14, "over_exit");
    check("exit_disp", 32'(disp_data), 32'h0000);

    // key_valid held for three cycles: second consume at edge k+2
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = 4'h5;
    @(posedge clk);
    m_apply(5);
    @(negedge clk);
    check_outputs("hold_k", 1'b1, 1'b0);
    @(negedge clk);
    check_outputs("hold_k1", 1'b0, 1'b0);
    @(posedge clk);
    m_apply(5);
    @(negedge clk);
    check_outputs("hold_k2", 1'b1, 1'b0);
    kif.key_valid = 1'b0;
    @(negedge clk);
    check_outputs("hold_k3", 1'b0, 1'b0);
    check("hold_disp", 32'(disp_data), 32'h0055);
    send_key(14, "hstart");
    send_key(14, "habort");

    // async reset mid-TURN with a handshake in flight
    send_key(7, "a7");
    send_key(14, "astart");
    send_key(2, "atake");
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = 4'h1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    kif.key_valid = 1'b0;
    m_reset();
    check_outputs("arst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("arst_rel", 1'b0, 1'b0);

    // random play
    for (int i = 0; i < 300; i++) begin
      if (m_state == 0) begin
        k = (m_entry == 0) ? int'($urandom_range(0, 9)) : 14;
      end else if (m_state == 1) begin
        r = int'($urandom_range(0, 19));
        if (r < 12) k = int'($urandom_range(0, 5));
        else if (r < 18) k = 15;
        else if (r < 19) k = 14;
        else k = int'($urandom_range(6, 13));
      end else begin
        k = ($urandom_range(0, 3) == 0) ? 14 : int'($urandom_range(0, 15));
      end
      send_key(k, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nim_turn_ctrl.md
# nim_turn_ctrl

Game sequencer between the keypad scanner and the four-digit seven-segment driver. It consumes key codes over the keypad's ready/ack handshake and runs a two-player take-away game: set up the starting count, take turns removing 1..MAX_TAKE units, and detect game end. It drives the 16-bit hex word shown on the display. It replaces ad-hoc key handling in the top level with a single registered FSM.

## Interface
- MAX_TAKE, 3, largest legal take per turn (1..15).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  keypad ready; held high until acknowledged.
- key_code  in  4  key value: 0-9, A-D are digits, E is "start/abort", F is "confirm"; stable while key_valid is high.
- key_ack  out  1  one-cycle acknowledge to the keypad.
- disp_data  out  16  word for the seven-segment driver (nibble [15:12] is the leftmost digit).
- cur_player  out  1  0 = player 1 to move, 1 = player 2 to move.
- game_over  out  1  high in the OVER state.
- move_err  out  1  one-cycle pulse when a confirm is rejected.
- state  out  2  00 SETUP, 01 TURN, 10 OVER (11 unused; it recovers to SETUP).

## Operation
- Key consumption: a key is consumed on a posedge where key_valid=1 and key_ack=0. At most one key is consumed per handshake. No key is consumed while key_ack=1.
- Internal registers:
  - entry[15:0], the setup shift register.
  - total[15:0], the unsigned remaining count.
  - take[3:0], the pending selection (0 = none).
  - winner, 1 bit.
- SETUP:
  - Any key 0-D: entry <= {entry[11:0], key_code}.
  - E with entry!=0: total <= entry, take <= 0, cur_player <= 0, go to TURN.
  - E with entry==0: ignored.
  - F: ignored.
- TURN:
  - Key k with 1<=k<=MAX_TAKE: take <= k. A later selection overwrites an earlier one.
  - Key 0 or any key above MAX_TAKE other than E/F: ignored.
  - F with take==0, or with {12'b0,take} > total: move_err pulses; total, take and player are unchanged.
  - F otherwise: total <= total - take, take <= 0.
    - If the new total is 0, the mover loses (misère rule): winner <= ~cur_player, go to OVER.
    - Else cur_player toggles.
  - E: abort. entry <= 0, take <= 0, go to SETUP.
- OVER:
  - E: entry <= 0, go to SETUP.
  - All other keys are consumed and ignored.
- Display:
  - SETUP: disp_data = entry.
  - TURN with take==0: disp_data = total.
  - TURN with take!=0: disp_data = {4'hA + cur_player, 4'h0, 4'h0, take}.
  - OVER: disp_data = {12'hEEE, 3'b0, winner} + 1, giving EEE1 or EEE2.
- Arithmetic: 16-bit unsigned throughout. Subtraction cannot underflow because of the guard.

## Timing
- Reset (async assert, sync release): state=SETUP, entry=0, total=0, take=0, winner=0, cur_player=0, key_ack=0, move_err=0, game_over=0, disp_data=16'h0000.
- All outputs are registered.
- Key seen at edge k:
  - All state and register updates, and move_err, take effect at edge k.
  - key_ack is high for cycle k..k+1 only.
- The producer must drop key_valid by edge k+2; the keypad does this by clearing ready one cycle after ack. If key_valid is still high at edge k+2, it is treated as a new key.
- disp_data reflects the consumed key one cycle after edge k, with the same latency as state.
- move_err is high for exactly one cycle per rejected F.
- Reset mid-handshake drops key_ack immediately. A key pending at release is consumed normally.
- state=11 goes to SETUP on the next edge with entry cleared. No key is consumed in that cycle.

## Test plan
- Setup entry: after reset, keys 1,2 then E -> disp_data 0x0012, then state=01, total=0x0012, cur_player=0.
- Normal turn: total=5, keys 2,F -> disp_data A002 after key 2, then total=3, cur_player=1, disp_data 0x0003.
- Rejection: total=2, keys 3,F -> move_err one-cycle pulse, total stays 2, cur_player unchanged. Also F with no take selected -> move_err pulse.
- Game end: total=1, player 2 to move, keys 1,F -> state=10, game_over=1, disp_data EEE1 (player 1 wins). Then E -> SETUP, disp_data 0x0000.
- Handshake: key_valid held high for 1 cycle after ack -> exactly one consume and one key_ack pulse. key_valid held high 3 cycles -> a second consume at edge k+2.
- Async reset mid-TURN (total=7, take=2) -> all outputs at reset values within the same cycle, state=SETUP.
